// File: rtl/adc_capture_ctrl.sv
// Double-banked ADC capture controller: optional level trigger, ping-pong bank
// fill with host handshakes, and drop accounting while both banks are busy.
module adc_capture_ctrl #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 16,
  parameter int RUN_BANKS = 0
) (
  input  logic              ADC_I_clk,
  input  logic              I_rst_n,
  input  logic              I_arm,
  input  logic              I_abort,
  input  logic              I_trigEnable,
  input  logic [DATA_W-1:0] I_trigLevel,
  input  logic              ADC_I_dataValid,
  input  logic [DATA_W-1:0] ADC_I_data,
  input  logic [1:0]        I_bankAck,
  output logic              O_wrEn,
  output logic              O_wrBank,
  output logic [ADDR_W-1:0] O_wrAddr,
  output logic [DATA_W-1:0] O_wrData,
  output logic [1:0]        O_bankFull,
  output logic              O_irq,
  output logic              O_overrun,
  output logic [15:0]       O_dropCount,
  output logic [1:0]        O_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CAP   = 2'd2;
  localparam logic [1:0] S_STALL = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [15:0]       RUN_N    = 16'(RUN_BANKS);

  logic [ADDR_W-1:0] addr_q;
  logic              bank_q;
  logic [15:0]       bank_cnt;

  logic        trig, do_wr, done;
  logic [1:0]  set_vec, full_nxt;
  logic [15:0] cnt_inc;

  // Abort suppresses the write, which also suppresses bank completion.
  always_comb begin
    trig     = $signed(ADC_I_data) >= $signed(I_trigLevel);
    do_wr    = !I_abort && ADC_I_dataValid &&
               (O_state == S_CAP || (O_state == S_WAIT && trig));
    done     = do_wr && (addr_q == ADDR_MAX);
    set_vec  = 2'b00;
    if (done) set_vec[bank_q] = 1'b1;
    full_nxt = (O_bankFull & ~I_bankAck) | set_vec;
    cnt_inc  = bank_cnt + 16'd1;
  end

  always_ff @(posedge ADC_I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_state     <= S_IDLE;
      O_wrEn      <= 1'b0;
      O_wrBank    <= 1'b0;
      O_wrAddr    <= '0;
      O_wrData    <= '0;
      O_bankFull  <= 2'b00;
      O_irq       <= 1'b0;
      O_overrun   <= 1'b0;
      O_dropCount <= 16'd0;
      addr_q      <= '0;
      bank_q      <= 1'b0;
      bank_cnt    <= 16'd0;
    end else begin
      O_wrEn     <= do_wr;
      O_irq      <= done;
      O_bankFull <= full_nxt;
      if (do_wr) begin
        O_wrAddr <= addr_q;
        O_wrBank <= bank_q;
        O_wrData <= ADC_I_data;
      end
      if (I_abort) begin
        O_state <= S_IDLE;
        addr_q  <= '0;
      end else begin
        case (O_state)
          S_IDLE: if (I_arm) begin
            O_overrun   <= 1'b0;
            O_dropCount <= 16'd0;
            bank_cnt    <= 16'd0;
            addr_q      <= '0;
            bank_q      <= O_bankFull[0] && !O_bankFull[1];
            O_state     <= (&O_bankFull) ? S_STALL : (I_trigEnable ? S_WAIT : S_CAP);
          end
          S_WAIT, S_CAP: if (do_wr) begin
            O_state <= S_CAP;
            if (done) begin
              addr_q   <= '0;
              bank_q   <= ~bank_q;
              bank_cnt <= cnt_inc;
              if (RUN_N != 16'd0 && cnt_inc == RUN_N) O_state <= S_IDLE;
              else if (full_nxt[~bank_q])             O_state <= S_STALL;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
          default: begin
            // Resume only on the registered flag, so the clearing-cycle sample drops.
            if (ADC_I_dataValid) begin
              O_overrun <= 1'b1;
              if (O_dropCount != 16'hFFFF) O_dropCount <= O_dropCount + 16'd1;
            end
            if (!O_bankFull[bank_q]) begin
              O_state <= S_CAP;
              addr_q  <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 Parameter ADDR_W, default 13: bank address width; bank depth = 2^ADDR_W samples.
REQ-002 Parameter DATA_W, default 16: ADC sample width.
REQ-003 Parameter RUN_BANKS, default 0: banks filled per run; 0 = continuous.
REQ-004 ADC_I_clk  in  1  sole clock; every input is synchronous to it.
REQ-005 I_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 I_arm  in  1  one-cycle pulse that starts a run.
REQ-007 I_abort  in  1  one-cycle pulse that ends a run.
REQ-008 I_trigEnable  in  1  1 = wait for threshold before capture; 0 = capture immediately.
REQ-009 I_trigLevel  in  DATA_W  signed trigger threshold.
REQ-010 ADC_I_dataValid  in  1  sample strobe.
REQ-011 ADC_I_data  in  DATA_W  signed sample.
REQ-012 I_bankAck  in  2  one-cycle pulse per bank: host has finished reading that bank.
REQ-013 O_wrEn  out  1  bank RAM write enable.
REQ-014 O_wrBank  out  1  target bank of the current write.
REQ-015 O_wrAddr  out  ADDR_W  write address.
REQ-016 O_wrData  out  DATA_W  write data.
REQ-017 O_bankFull  out  2  per-bank full flags.
REQ-018 O_irq  out  1  one-cycle pulse when a bank completes.
REQ-019 O_overrun  out  1  sticky flag: samples were dropped.
REQ-020 O_dropCount  out  16  count of dropped samples, saturating.
REQ-021 O_state  out  2  current state: IDLE=0, WAIT_TRIG=1, CAPTURE=2, STALL=3.

Function
REQ-022 All outputs shall be registered.
REQ-023 Write latency shall be 1 cycle: a sample accepted in cycle N drives O_wrEn/O_wrData/O_wrAddr/O_wrBank in cycle N+1.
REQ-024 IDLE: I_arm -> WAIT_TRIG if I_trigEnable, else CAPTURE.
REQ-025 Arming shall clear O_overrun, O_dropCount, the bank counter and the address, and shall set the write bank to the lowest-numbered bank whose O_bankFull is 0.
REQ-026 If both banks are full at arm time, the block shall enter STALL targeting bank 0.
REQ-027 WAIT_TRIG: a valid sample with signed ADC_I_data >= I_trigLevel shall be written at address 0 and the state shall go to CAPTURE.
REQ-028 WAIT_TRIG: non-triggering samples shall not be written and shall not count as drops.
REQ-029 CAPTURE: each valid sample shall be written at the current address, then the address increments.
REQ-030 A write to address 2^ADDR_W-1 shall complete the bank: set O_bankFull[bank] in the same cycle as that write, pulse O_irq in the same cycle, toggle the bank and wrap the address to 0.
REQ-031 After a bank completes and RUN_BANKS!=0 and the completed-bank count equals RUN_BANKS, the state shall go to IDLE.
REQ-032 Otherwise, if the new bank's O_bankFull is 1, the state shall go to STALL; else it shall stay in CAPTURE.
REQ-033 STALL: valid samples shall be dropped: no write, O_overrun set, O_dropCount incremented, saturating at 16'hFFFF.
REQ-034 STALL: when the target bank's full flag clears, the state shall go to CAPTURE with address 0; the sample in the clearing cycle shall be dropped.
REQ-035 I_bankAck[b] shall clear O_bankFull[b] next cycle in any state.
REQ-036 If a bank's set and its ack occur in the same cycle, set shall win.
REQ-037 An ack to an empty bank shall be ignored.
REQ-038 I_abort in any state shall go to IDLE next cycle with no further writes and the address reset to 0.
REQ-039 I_abort shall preserve O_bankFull, O_overrun and O_dropCount; a partially written bank is not flagged.
REQ-040 I_abort shall have priority over I_arm and over bank completion in the same cycle.
REQ-041 I_arm outside IDLE shall be ignored.

Reset
REQ-042 While I_rst_n=0: state IDLE; O_wrEn, O_irq, O_overrun = 0; O_bankFull = 2'b00; O_wrAddr, O_wrBank, O_wrData, O_dropCount = 0; internal counters = 0.
REQ-043 Reset mid-capture shall discard the run with no write in the cycle after deassertion.

Verification (ADDR_W=4, RUN_BANKS=0)
REQ-044 Arm with trigEnable=0, 16 valid samples 0..15 -> writes to bank 0 at addr 0..15; O_bankFull=01 and O_irq pulse on the 16th write; the next sample goes to bank 1, addr 0.
REQ-045 Arm with trigEnable=1, trigLevel=100, samples 50, 99, 100, 20 -> only 100 (addr 0) and 20 (addr 1) are written; O_state 1 -> 2.
REQ-046 Fill both banks with no ack, then 5 more samples -> STALL, O_overrun=1, O_dropCount=5; I_bankAck=01 -> next sample written to bank 0, addr 0.
REQ-047 Ack of bank 0 in the same cycle as its completing write -> O_bankFull[0] stays 1.
REQ-048 I_abort at addr 7 of bank 1 -> IDLE, O_bankFull unchanged; re-arm clears O_overrun and O_dropCount and starts at the lowest empty bank, addr 0.
REQ-049 I_rst_n pulsed low mid-CAPTURE -> all outputs at reset values asynchronously; valid samples after release produce no writes until I_arm.
